// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package if_pkg;

  localparam int IF_XLEN = 32;
  localparam logic [IF_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] instr;
    logic               fault;
  } if_entry_t;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic               fault;
  } if_tag_t;

  function automatic logic is_misaligned(input logic [IF_XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with clear; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign pop_data = mem_q[rd_ptr_q[PW-1:0]];

  assign do_push  = push & ~full & ~clear;
  assign do_pop   = pop & ~empty & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues PC fetches under a credit limit, tags them in order and
// buffers responses for decode; a flush drops buffered and in-flight fetches.
module instr_fetch_buffer
  import if_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter int XLEN    = IF_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            pc_valid,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_fault,
  input  logic            dec_ready,
  output logic            err_spurious
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam int CW = $clog2(DEPTH) + 2;

  logic [FW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic [OW-1:0] outstanding;
  logic          tag_empty, tag_full;
  logic [CW-1:0] inflight;
  logic          credit_ok, grant, rsp, rsp_keep, fifo_pop;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic          err_spurious_q, err_spurious_d;
  if_entry_t     fifo_wdata, fifo_rdata;
  if_tag_t       tag_wdata, tag_rdata;

  // Credits count both buffered and in-flight words so a response always fits.
  assign inflight   = CW'(outstanding) + CW'(fifo_count);
  assign credit_ok  = (inflight < CW'(DEPTH)) & ~tag_full;
  assign imem_req   = reset & pc_valid & credit_ok & ~flush;
  assign imem_addr  = {pc_addr[XLEN-1:2], 2'b00};
  assign grant      = imem_req & imem_gnt;
  assign pc_advance = grant;

  assign rsp      = imem_rvalid & ~tag_empty;
  assign rsp_keep = rsp & (drop_cnt_q == '0) & ~flush & ~fifo_full;
  assign fifo_pop = ~fifo_empty & dec_ready & ~flush;

  always_comb begin
    tag_wdata.pc    = pc_addr;
    tag_wdata.fault = is_misaligned(pc_addr);
    fifo_wdata.pc    = tag_rdata.pc;
    fifo_wdata.fault = tag_rdata.fault;
    fifo_wdata.instr = tag_rdata.fault ? NOP_INSTR : imem_rdata;
  end

  // The tag queue is kept through a flush so late responses still retire their tag.
  always_comb begin
    drop_cnt_d     = drop_cnt_q;
    err_spurious_d = err_spurious_q | (imem_rvalid & tag_empty);
    if (flush) begin
      drop_cnt_d = outstanding - {{(OW-1){1'b0}}, rsp};
    end else if (rsp && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - {{(OW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q     <= '0;
      err_spurious_q <= 1'b0;
    end else begin
      drop_cnt_q     <= drop_cnt_d;
      err_spurious_q <= err_spurious_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(if_tag_t)),
    .DEPTH (MAX_OUT)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (reset),
    .push      (grant),
    .push_data (tag_wdata),
    .pop       (rsp),
    .clear     (1'b0),
    .pop_data  (tag_rdata),
    .count     (outstanding),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  sync_fifo #(
    .WIDTH ($bits(if_entry_t)),
    .DEPTH (DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst_n     (reset),
    .push      (rsp_keep),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .clear     (flush),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign if_valid     = ~fifo_empty;
  assign if_pc        = fifo_rdata.pc;
  assign if_instr     = fifo_rdata.instr;
  assign if_fault     = fifo_rdata.fault;
  assign err_spurious = err_spurious_q;

endmodule
